rom_port_arb: RTL and testbench
===============================

Name: rom_port_arb

Overview:
- Cycle-level arbiter and sequencer for the single ROM0 memory port.
- Shared by four requesters: CPU bus (0), framebuffer bitmap transform (1), plane spot renderer (2), column renderer (3).
- Replaces combinational address muxing with registered grant, hold and acknowledge, so render engines and CPU can issue overlapping requests.
- Sits between the mapper datapath and the ROM0 memory interface.

Parameters:
- ACC_LAT, 4, clocks each access holds mem_oe/mem_we asserted before data is sampled (min 1).
- CPU_MAX, 3, max consecutive CPU grants while another requester waits.
- AW, 23, word-port address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  4  per-requester request level; bit n = requester n.
- burst  in  4  per-requester 2-word read burst flag; sampled with req.
- we_hi  in  4  per-requester high-byte write strobe; a request with either strobe set is a write.
- we_lo  in  4  per-requester low-byte write strobe.
- addr  in  4*AW  packed byte addresses; requester n at [n*AW +: AW].
- wdat  in  64  packed write data, 16 bits per requester.
- ack  out  4  one-clock pulse per completed word to the granted requester.
- rdat  out  16  read data, valid in the ack cycle, held until the next ack.
- busy  out  1  high from grant to final ack.
- mem_addr  out  AW  to ROM0.
- mem_di  out  16  to ROM0.
- mem_oe  out  1  to ROM0.
- mem_we_hi  out  1  to ROM0.
- mem_we_lo  out  1  to ROM0.
- mem_do  in  16  from ROM0.

Behaviour:
- Reset: state IDLE; ack=0, rdat=0, busy=0, mem_oe=0, mem_we_hi=0, mem_we_lo=0, mem_addr=0, mem_di=0; rr pointer=1; cpu_run=0; all stat counters 0.
- FSM states: IDLE, ACCESS, DONE, BURST2.
- IDLE:
  - Grant when any req bit is high.
  - Requester 0 wins unless cpu_run==CPU_MAX and some of req[3:1] is set.
  - Otherwise round-robin among 1..3, starting at the rr pointer.
  - On grant: latch addr, wdat, strobes and burst; drive mem_*; busy=1; enter ACCESS.
- ACCESS:
  - Hold mem_* stable for ACC_LAT clocks, counted by a 4-bit counter.
  - mem_oe=1 for a read; mem_we_hi/mem_we_lo for a write; never both oe and we.
  - On the last clock, register mem_do into rdat; go to DONE.
- DONE:
  - ack[g]=1 for exactly one clock; mem strobes low.
  - If a read burst is latched and this is the first word: mem_addr += 2, go to BURST2.
  - Else: busy=0, go to IDLE.
- BURST2:
  - Same as ACCESS for the second word; then DONE, which returns to IDLE.
  - Two ack pulses total, separated by ACC_LAT+1 clocks.
- Requester handshake:
  - Hold req, addr and wdat until ack; drop req in the ack cycle or the cycle after.
  - A req still high in the IDLE cycle after ack is a new request.
- Arbitration details:
  - A burst flag on a write is ignored (single word).
  - Minimum turnaround: IDLE costs one clock between transactions. Back-to-back throughput is one word per ACC_LAT+2 clocks.
  - rr pointer advances to (g mod 3)+1 after a grant to g ∈ {1,2,3}; unchanged on a CPU grant.
  - cpu_run increments on each CPU grant while req[3:1]≠0, and clears on any non-CPU grant or when req[3:1]==0. Width is sized to CPU_MAX.
- Boundary conditions:
  - Burst address wrap: mem_addr+2 wraps modulo 2^AW.
  - Simultaneous all-request: exactly one grant per IDLE; no combinational ack.
  - Requester deasserts req mid-access: the access completes, ack still pulses, and the data is discarded by the requester.
  - rst mid-access: immediate return to reset values; mem strobes low the next clock; no ack issued.

Optional Feature:
- Macro: ROM_PORT_ARB_STATS_EN.
- Defined:
  - Adds output stats (4*16): per-requester saturating 16-bit count of granted words (0xFFFF sticks).
  - Adds input stats_clr (1): synchronous clear, which wins over a simultaneous increment.
- Undefined: no ports and no counters; the rest of the behaviour is identical.

Decomposition:
- Shared package/include holds:
  - Requester index constants REQ_CPU=0, REQ_FBUF=1, REQ_SPOT=2, REQ_COLU=3.
  - FSM state encodings.
  - The packed-slice width constant.
- Natural sub-module rr_pick3: combinational round-robin selector over req[3:1] given the pointer. Outputs grant index plus valid.

Test Plan:
- Single CPU read, ACC_LAT=4, addr=0x000100, mem_do=0xBEEF:
  - mem_oe high exactly 4 clocks.
  - ack[0] pulses 6 clocks after req rises; rdat=0xBEEF.
- fbuf burst read at 0x7FFFFE: mem_addr 0x7FFFFE then 0x000000; two ack[1] pulses 5 clocks apart; rdat matches each word.
- req=4'b1111 held, CPU_MAX=3: grant order is 0,0,0,1,0,0,0,2,0,0,0,3; no requester starves.
- Column write, we_lo only, wdat=0x12AB at 0x000201: mem_we_lo high 4 clocks, mem_we_hi and mem_oe low; ack[3] single pulse.
- rst asserted in the 2nd ACCESS clock: next clock all mem strobes 0, busy 0, no ack; a fresh CPU req completes normally.
- With ROM_PORT_ARB_STATS_EN, 0x10005 spot grants: stats[2]=0xFFFF; stats_clr then 0.

Source files
------------

// File: rtl/rom_port_arb_pkg.sv
// Shared definitions for the ROM0 port arbiter: requester indices, FSM encoding
// and the per-requester packed slice width.
package rom_port_arb_pkg;

    localparam int REQ_CPU  = 0;
    localparam int REQ_FBUF = 1;
    localparam int REQ_SPOT = 2;
    localparam int REQ_COLU = 3;
    localparam int NREQ     = 4;

    // Width of one requester's slice in the packed wdat/stats buses.
    localparam int DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_BURST2 = 2'd3
    } arb_state_e;

    function automatic logic [NREQ-1:0] req_onehot(input logic [1:0] idx);
        req_onehot = 4'b0001 << idx;
    endfunction

    // Round-robin pointer successor after a grant to requester 1..3.
    function automatic logic [1:0] rr_next(input logic [1:0] g);
        case (g)
            2'd1:    rr_next = 2'd2;
            2'd2:    rr_next = 2'd3;
            default: rr_next = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/rom_port_arb_rr_pick3.sv
// Combinational round-robin selector over requesters 1..3, searching upward
// from the pointer and wrapping 3 -> 1.
module rr_pick3
    import rom_port_arb_pkg::*;
(
    input  logic [2:0] req3,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       vld
);

    int base;

    always_comb begin
        idx  = 2'd0;
        vld  = 1'b0;
        // A pointer of 0 never occurs in operation; treat it as 1.
        base = (ptr == 2'd0) ? 0 : int'(ptr) - 1;
        for (int k = 0; k < 3; k++) begin
            if (!vld && req3[(base + k) % 3]) begin
                vld = 1'b1;
                idx = 2'(((base + k) % 3) + 1);
            end
        end
    end

endmodule

// File: rtl/rom_port_arb.sv
// ROM0 port arbiter/sequencer: registered grant, timed access and ack pulse.
// Optional per-requester word counters when ROM_PORT_ARB_STATS_EN is defined.
module rom_port_arb
    import rom_port_arb_pkg::*;
#(
    parameter int ACC_LAT = 4,
    parameter int CPU_MAX = 3,
    parameter int AW      = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      burst,
    input  logic [NREQ-1:0]      we_hi,
    input  logic [NREQ-1:0]      we_lo,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdat,
`ifdef ROM_PORT_ARB_STATS_EN
    input  logic                 stats_clr,
    output logic [NREQ*DW-1:0]   stats,
`endif
    output logic [NREQ-1:0]      ack,
    output logic [DW-1:0]        rdat,
    output logic                 busy,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_di,
    output logic                 mem_oe,
    output logic                 mem_we_hi,
    output logic                 mem_we_lo,
    input  logic [DW-1:0]        mem_do
);

    localparam int              CRW       = (CPU_MAX < 2) ? 1 : $clog2(CPU_MAX + 1);
    localparam logic [CRW-1:0]  CPU_MAX_C = CRW'(CPU_MAX);
    localparam logic [3:0]      CNT_LAST  = 4'(ACC_LAT - 1);

    arb_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             lat_burst_q, lat_burst_d;
    logic             lat_we_hi_q, lat_we_hi_d;
    logic             lat_we_lo_q, lat_we_lo_d;
    logic             second_q, second_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [CRW-1:0]   cpu_run_q, cpu_run_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [DW-1:0]    rdat_q, rdat_d;
    logic             busy_q, busy_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [DW-1:0]    mem_di_q, mem_di_d;
    logic             mem_oe_q, mem_oe_d;
    logic             mem_we_hi_q, mem_we_hi_d;
    logic             mem_we_lo_q, mem_we_lo_d;

    logic [1:0]       rr_idx;
    logic             rr_vld;
    logic             others_req;
    logic             cpu_win;
    logic [1:0]       gnt_idx;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdat;
    logic             sel_wh, sel_wl;

    rr_pick3 u_pick (
        .req3 (req[3:1]),
        .ptr  (rr_ptr_q),
        .idx  (rr_idx),
        .vld  (rr_vld)
    );

    // CPU has priority until it has run CPU_MAX times while others wait.
    assign others_req = |req[3:1];
    assign cpu_win    = req[REQ_CPU] && !((cpu_run_q == CPU_MAX_C) && others_req);
    assign gnt_idx    = cpu_win ? 2'(REQ_CPU) : rr_idx;
    assign sel_addr   = addr[int'(gnt_idx)*AW +: AW];
    assign sel_wdat   = wdat[int'(gnt_idx)*DW +: DW];
    assign sel_wh     = we_hi[gnt_idx];
    assign sel_wl     = we_lo[gnt_idx];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        lat_burst_d = lat_burst_q;
        lat_we_hi_d = lat_we_hi_q;
        lat_we_lo_d = lat_we_lo_q;
        second_d    = second_q;
        rr_ptr_d    = rr_ptr_q;
        cpu_run_d   = cpu_run_q;
        ack_d       = '0;
        rdat_d      = rdat_q;
        busy_d      = busy_q;
        mem_addr_d  = mem_addr_q;
        mem_di_d    = mem_di_q;
        mem_oe_d    = mem_oe_q;
        mem_we_hi_d = mem_we_hi_q;
        mem_we_lo_d = mem_we_lo_q;

        if (!others_req) begin
            cpu_run_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cpu_win || rr_vld) begin
                    gnt_d       = gnt_idx;
                    lat_we_hi_d = sel_wh;
                    lat_we_lo_d = sel_wl;
                    // Writes are always single-word, whatever the burst flag says.
                    lat_burst_d = burst[gnt_idx] && !(sel_wh || sel_wl);
                    second_d    = 1'b0;
                    mem_addr_d  = sel_addr;
                    mem_di_d    = sel_wdat;
                    mem_oe_d    = !(sel_wh || sel_wl);
                    mem_we_hi_d = sel_wh;
                    mem_we_lo_d = sel_wl;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_ACCESS;
                    if (cpu_win) begin
                        if (others_req) begin
                            cpu_run_d = cpu_run_q + CRW'(1);
                        end
                    end else begin
                        cpu_run_d = '0;
                        rr_ptr_d  = rr_next(gnt_idx);
                    end
                end
            end

            ST_ACCESS, ST_BURST2: begin
                if (cnt_q == CNT_LAST) begin
                    if (!lat_we_hi_q && !lat_we_lo_q) begin
                        rdat_d = mem_do;
                    end
                    ack_d       = req_onehot(gnt_q);
                    mem_oe_d    = 1'b0;
                    mem_we_hi_d = 1'b0;
                    mem_we_lo_d = 1'b0;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_DONE: begin
                if (lat_burst_q && !second_q) begin
                    mem_addr_d = mem_addr_q + AW'(2);
                    mem_oe_d   = 1'b1;
                    second_d   = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_BURST2;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            gnt_q       <= '0;
            lat_burst_q <= 1'b0;
            lat_we_hi_q <= 1'b0;
            lat_we_lo_q <= 1'b0;
            second_q    <= 1'b0;
            rr_ptr_q    <= 2'd1;
            cpu_run_q   <= '0;
            ack_q       <= '0;
            rdat_q      <= '0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_di_q    <= '0;
            mem_oe_q    <= 1'b0;
            mem_we_hi_q <= 1'b0;
            mem_we_lo_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            lat_burst_q <= lat_burst_d;
            lat_we_hi_q <= lat_we_hi_d;
            lat_we_lo_q <= lat_we_lo_d;
            second_q    <= second_d;
            rr_ptr_q    <= rr_ptr_d;
            cpu_run_q   <= cpu_run_d;
            ack_q       <= ack_d;
            rdat_q      <= rdat_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_di_q    <= mem_di_d;
            mem_oe_q    <= mem_oe_d;
            mem_we_hi_q <= mem_we_hi_d;
            mem_we_lo_q <= mem_we_lo_d;
        end
    end

    assign ack       = ack_q;
    assign rdat      = rdat_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_di    = mem_di_q;
    assign mem_oe    = mem_oe_q;
    assign mem_we_hi = mem_we_hi_q;
    assign mem_we_lo = mem_we_lo_q;

`ifdef ROM_PORT_ARB_STATS_EN
    // Words are counted on their ack pulse; clear beats a same-cycle increment.
    logic [DW-1:0] stats_q [NREQ];
    logic [DW-1:0] stats_d [NREQ];

    always_comb begin
        for (int n = 0; n < NREQ; n++) begin
            stats_d[n] = stats_q[n];
            if (stats_clr) begin
                stats_d[n] = '0;
            end else if (ack_q[n] && (stats_q[n] != {DW{1'b1}})) begin
                stats_d[n] = stats_q[n] + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < NREQ; n++) begin
            if (rst) begin
                stats_q[n] <= '0;
            end else begin
                stats_q[n] <= stats_d[n];
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stats
        assign stats[g*DW +: DW] = stats_q[g];
    end
`endif

endmodule

// File: tb/tb_rom_port_arb.sv
// Scoreboard bench for rom_port_arb: directed transactions push expected acks,
// a negedge monitor pops and compares them.
module tb_rom_port_arb;

    localparam int AW = 23;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      req = '0;
    logic [3:0]      burst = '0;
    logic [3:0]      we_hi = '0;
    logic [3:0]      we_lo = '0;
    logic [4*AW-1:0] addr = '0;
    logic [63:0]     wdat = '0;
    logic [3:0]      ack;
    logic [15:0]     rdat;
    logic            busy;
    logic [AW-1:0]   mem_addr;
    logic [15:0]     mem_di;
    logic            mem_oe;
    logic            mem_we_hi;
    logic            mem_we_lo;
    logic [15:0]     mem_do;
`ifdef ROM_PORT_ARB_STATS_EN
    logic            stats_clr = 1'b0;
    logic [63:0]     stats;
`endif

    int nvec = 0;
    int nerr = 0;

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] rd;
        logic        chk_rd;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    rom_port_arb #(.ACC_LAT(4), .CPU_MAX(3), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .burst     (burst),
        .we_hi     (we_hi),
        .we_lo     (we_lo),
        .addr      (addr),
        .wdat      (wdat),
`ifdef ROM_PORT_ARB_STATS_EN
        .stats_clr (stats_clr),
        .stats     (stats),
`endif
        .ack       (ack),
        .rdat      (rdat),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_di    (mem_di),
        .mem_oe    (mem_oe),
        .mem_we_hi (mem_we_hi),
        .mem_we_lo (mem_we_lo),
        .mem_do    (mem_do)
    );

    always #5 clk = ~clk;

    // ROM model: one special word, otherwise address-derived data.
    assign mem_do = (mem_addr == 23'h000100) ? 16'hBEEF : (mem_addr[15:0] ^ 16'h5A5A);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ack !== 4'b0000) begin
            if (sbq.size() == 0) begin
                chk("ack_unexpected", 32'(ack), 32'h0);
            end else begin
                mon_e = sbq.pop_front();
                chk("ack_idx", 32'(ack), 32'(4'b0001 << mon_e.idx));
                if (mon_e.chk_rd) chk("rdat", 32'(rdat), 32'(mon_e.rd));
            end
        end
    end

    task automatic push(input int n, input logic [15:0] rd, input logic c);
        exp_t e;
        e.idx = 2'(n);
        e.rd = rd;
        e.chk_rd = c;
        sbq.push_back(e);
    endtask

    // Issue one request from requester n, observe strobes/addresses until nacks acks.
    task automatic txn(input int n, input logic [AW-1:0] a, input logic [15:0] wd,
                       input logic wh, input logic wl, input logic bst, input int nacks,
                       output int oe_c, output int weh_c, output int wel_c,
                       output int a1, output int a2,
                       output logic [AW-1:0] ad1, output logic [AW-1:0] ad2,
                       output logic [15:0] di1);
        int got;
        bit seen1, seen2;
        got = 0; seen1 = 0; seen2 = 0;
        oe_c = 0; weh_c = 0; wel_c = 0; a1 = 0; a2 = 0;
        ad1 = '0; ad2 = '0; di1 = '0;
        @(posedge clk); #1;
        addr[n*AW +: AW] = a;
        wdat[n*16 +: 16] = wd;
        we_hi[n] = wh;
        we_lo[n] = wl;
        burst[n] = bst;
        req[n] = 1'b1;
        for (int k = 1; k <= 40 && got < nacks; k++) begin
            @(negedge clk);
            if (mem_oe) oe_c++;
            if (mem_we_hi) weh_c++;
            if (mem_we_lo) wel_c++;
            if (mem_oe || mem_we_hi || mem_we_lo) begin
                if (got == 0 && !seen1) begin ad1 = mem_addr; di1 = mem_di; seen1 = 1; end
                if (got == 1 && !seen2) begin ad2 = mem_addr; seen2 = 1; end
            end
            if (ack[n]) begin
                got++;
                if (got == 1) a1 = k; else a2 = k;
                if (got == nacks) begin
                    req[n] = 1'b0; we_hi[n] = 1'b0; we_lo[n] = 1'b0; burst[n] = 1'b0;
                end
            end
        end
        if (got < nacks) chk("txn_timeout", 32'(got), 32'(nacks));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int oe_c, weh_c, wel_c, a1, a2, got;
        logic [AW-1:0] ad1, ad2;
        logic [15:0] di1;

        do_reset();
        @(negedge clk);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_oe", 32'(mem_oe), 32'h0);
        chk("rst_we", 32'({mem_we_hi, mem_we_lo}), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_di", 32'(mem_di), 32'h0);
        chk("rst_rdat", 32'(rdat), 32'h0);

        // Single CPU read
        push(0, 16'hBEEF, 1'b1);
        txn(0, 23'h000100, 16'h0, 1'b0, 1'b0, 1'b0, 1, oe_c, weh_c, wel_c, a1, a2, ad1, ad2, di1);
        chk("cpu_oe_clocks", 32'(oe_c), 32'd4);
        chk("cpu_ack_latency", 32'(a1), 32'd6);
        chk("cpu_addr", 32'(ad1), 32'h100);
        repeat (3) @(negedge clk);
        chk("rdat_hold", 32'(rdat), 32'hBEEF);
        chk("cpu_busy_done", 32'(busy), 32'h0);

        // fbuf burst read wrapping at the top of the address space
        push(1, 16'hA5A4, 1'b1);
        push(1, 16'h5A5A, 1'b1);
        txn(1, 23'h7FFFFE, 16'h0, 1'b0, 1'b0, 1'b1, 2, oe_c, weh_c, wel_c, a1, a2, ad1, ad2, di1);
        chk("burst_addr1", 32'(ad1), 32'h7FFFFE);
        chk("burst_addr2", 32'(ad2), 32'h000000);
        chk("burst_ack_gap", 32'(a2 - a1), 32'd5);
        chk("burst_oe_clocks", 32'(oe_c), 32'd8);

        // Column write, low byte only
        push(3, 16'h0, 1'b0);
        txn(3, 23'h000201, 16'h12AB, 1'b0, 1'b1, 1'b0, 1, oe_c, weh_c, wel_c, a1, a2, ad1, ad2, di1);
        chk("wr_we_lo_clocks", 32'(wel_c), 32'd4);
        chk("wr_we_hi_clocks", 32'(weh_c), 32'd0);
        chk("wr_oe_clocks", 32'(oe_c), 32'd0);
        chk("wr_addr", 32'(ad1), 32'h201);
        chk("wr_di", 32'(di1), 32'h12AB);
        repeat (8) @(negedge clk);

        // All four requesting continuously: CPU_MAX CPU grants per other grant
        do_reset();
        for (int g = 0; g < 3; g++) begin
            push(0, 16'hBEEF, 1'b1); push(0, 16'hBEEF, 1'b1); push(0, 16'hBEEF, 1'b1);
            push(g + 1, 16'(16'h5A5A ^ (16'h0010 * 16'(g + 1))), 1'b1);
        end
        @(posedge clk); #1;
        addr = {23'h000030, 23'h000020, 23'h000010, 23'h000100};
        req = 4'b1111;
        got = 0;
        for (int k = 0; k < 120 && got < 12; k++) begin
            @(negedge clk);
            if (ack !== 4'b0000) begin
                got++;
                if (got == 12) req = 4'b0000;
            end
        end
        chk("all_req_grants", 32'(got), 32'd12);
        repeat (8) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        // Reset in the second ACCESS clock aborts the access without an ack
        @(posedge clk); #1;
        addr[0 +: AW] = 23'h000040;
        req[0] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        req[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_oe", 32'(mem_oe), 32'h0);
        chk("abort_we", 32'({mem_we_hi, mem_we_lo}), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_ack", 32'(ack), 32'h0);
        repeat (8) @(negedge clk);
        push(0, 16'hBEEF, 1'b1);
        txn(0, 23'h000100, 16'h0, 1'b0, 1'b0, 1'b0, 1, oe_c, weh_c, wel_c, a1, a2, ad1, ad2, di1);
        chk("post_rst_latency", 32'(a1), 32'd6);

`ifdef ROM_PORT_ARB_STATS_EN
        repeat (3) @(negedge clk);
        chk("stats_cpu", 32'(stats[15:0]), 32'd1);
        chk("stats_others", 32'(stats[63:16]), 32'h0);
        @(posedge clk); #1 stats_clr = 1'b1;
        @(posedge clk); #1 stats_clr = 1'b0;
        @(negedge clk);
        chk("stats_clr", 32'(stats[15:0]), 32'h0);
`endif

        repeat (4) @(negedge clk);
        chk("sb_final_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
